// File: rtl/g15_pkg.sv
// Shared drum-timing constants, sequencer state type and transfer-length helper
// for the G-15 command sequencer slice.
package g15_pkg;

    localparam int unsigned WORD_BITS      = 29;
    localparam int unsigned WORDS_PER_LINE = 108;

    typedef logic [4:0] bit_num_t;
    typedef logic [6:0] word_cnt_t;

    localparam bit_num_t LAST_BIT = bit_num_t'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        ST_HALT,
        ST_WAIT_N,
        ST_READ_CMD,
        ST_WAIT_T,
        ST_XFER
    } seq_state_t;

    // Counter holds "words remaining after this one". A request of 107 means a
    // full 108-word line; otherwise 0 and 1 both mean a single word.
    function automatic word_cnt_t xfer_count_load(input word_cnt_t words);
        if (words == word_cnt_t'(WORDS_PER_LINE - 1))
            return words;
        else if (words == '0)
            return '0;
        else
            return words - word_cnt_t'(1);
    endfunction

endpackage

// File: rtl/command_state_sequencer_if.sv
// Drum timing, command fields and status bundle between the drum/command logic
// and the command state sequencer.
interface command_state_sequencer_if;
    import g15_pkg::*;

    logic      BIT_TICK;
    logic      T0;
    logic      N_MATCH;
    logic      T_MATCH;
    logic      IMMEDIATE;
    word_cnt_t XFER_WORDS;
    logic      GO;
    logic      SINGLE_CMD;

    logic      RC;
    logic      TR;
    logic      WAIT_RC;
    logic      WAIT_TR;
    logic      CR;
    bit_num_t  BIT_NUM;
    logic      HALTED;
    logic      CMD_DONE;

    modport master (
        output BIT_TICK, T0, N_MATCH, T_MATCH, IMMEDIATE, XFER_WORDS, GO, SINGLE_CMD,
        input  RC, TR, WAIT_RC, WAIT_TR, CR, BIT_NUM, HALTED, CMD_DONE
    );

    modport slave (
        input  BIT_TICK, T0, N_MATCH, T_MATCH, IMMEDIATE, XFER_WORDS, GO, SINGLE_CMD,
        output RC, TR, WAIT_RC, WAIT_TR, CR, BIT_NUM, HALTED, CMD_DONE
    );

endinterface

// File: rtl/bit_time_counter.sv
// Drum bit-time counter: advances per BIT_TICK, wraps after the last bit and is
// resynchronised to bit 0 by the word-start mark.
module bit_time_counter
    import g15_pkg::*;
(
    input  logic     CLOCK,
    input  logic     rst,
    input  logic     BIT_TICK,
    input  logic     T0,
    output bit_num_t BIT_NUM
);

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            BIT_NUM <= '0;
        end else if (BIT_TICK) begin
            if (T0 || BIT_NUM == LAST_BIT)
                BIT_NUM <= '0;
            else
                BIT_NUM <= BIT_NUM + bit_num_t'(1);
        end
    end

endmodule

// File: rtl/command_state_sequencer.sv
// Command state sequencer: waits for the next-command word, reads it, waits for
// the T word unless immediate, then runs the transfer for the requested length.
module command_state_sequencer
    import g15_pkg::*;
(
    input  logic                      CLOCK,
    input  logic                      rst,
    command_state_sequencer_if.slave  bus
);

    seq_state_t state;
    seq_state_t state_nx;
    word_cnt_t  word_cnt;
    bit_num_t   bit_num;
    logic       cr_q;
    logic       done_q;
    logic       word_start;
    logic       xfer_end;

    assign word_start = bus.BIT_TICK & bus.T0;
    assign xfer_end   = (state == ST_XFER) && word_start && (word_cnt == '0);

    bit_time_counter u_bit_time_counter (
        .CLOCK    (CLOCK),
        .rst      (rst),
        .BIT_TICK (bus.BIT_TICK),
        .T0       (bus.T0),
        .BIT_NUM  (bit_num)
    );

    always_ff @(posedge CLOCK) begin
        if (rst)
            state <= ST_HALT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (bus.BIT_TICK) begin
            case (state)
                ST_HALT:
                    if (bus.GO)
                        state_nx = ST_WAIT_N;
                ST_WAIT_N:
                    if (!bus.GO)
                        state_nx = ST_HALT;
                    else if (bus.T0 && bus.N_MATCH)
                        state_nx = ST_READ_CMD;
                ST_READ_CMD:
                    // A T match on the closing word mark skips WAIT_T entirely.
                    if (bus.T0)
                        state_nx = (bus.IMMEDIATE || bus.T_MATCH) ? ST_XFER : ST_WAIT_T;
                ST_WAIT_T:
                    if (bus.T0 && bus.T_MATCH)
                        state_nx = ST_XFER;
                ST_XFER:
                    if (xfer_end) begin
                        if (!bus.GO || bus.SINGLE_CMD)
                            state_nx = ST_HALT;
                        else if (bus.N_MATCH)
                            state_nx = ST_READ_CMD;
                        else
                            state_nx = ST_WAIT_N;
                    end
                default:
                    state_nx = ST_HALT;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            word_cnt <= '0;
            cr_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            // Shift strobe follows ticks that land on bit times 1..28 of the command word.
            cr_q   <= bus.BIT_TICK && !bus.T0 && (state == ST_READ_CMD) && (bit_num != LAST_BIT);
            done_q <= xfer_end;
            if (state == ST_READ_CMD && word_start)
                word_cnt <= xfer_count_load(bus.XFER_WORDS);
            else if (state == ST_XFER && word_start && word_cnt != '0)
                word_cnt <= word_cnt - word_cnt_t'(1);
        end
    end

    always_comb begin
        bus.RC       = (state == ST_READ_CMD);
        bus.TR       = (state == ST_XFER);
        bus.WAIT_RC  = (state == ST_WAIT_N);
        bus.WAIT_TR  = (state == ST_WAIT_T);
        bus.HALTED   = (state == ST_HALT);
        bus.CR       = cr_q;
        bus.CMD_DONE = done_q;
        bus.BIT_NUM  = bit_num;
    end

endmodule

// File: tb/tb_command_state_sequencer.sv
// Self-checking bench for command_state_sequencer: fixed vector table, directed
// multi-word sequences and randomized traffic against a word-level reference model.
module tb_command_state_sequencer;

    logic CLOCK = 1'b0;
    logic rst;

    command_state_sequencer_if bus();

    command_state_sequencer dut (
        .CLOCK (CLOCK),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: tracks words still to transfer rather than a down-counter.
    typedef enum int {M_HALT, M_WAIT_N, M_READ, M_WAIT_T, M_XFER} mstate_t;
    mstate_t m_st;
    int      m_bit;
    int      m_left;
    bit      m_cr;
    bit      m_done;
    bit      m_valid = 1'b0;

    function automatic int xfer_len(input int w);
        if (w == 0)   return 1;
        if (w == 107) return 108;
        return w;
    endfunction

    task automatic model_step();
        int nb;
        if (rst) begin
            m_st = M_HALT; m_bit = 0; m_left = 0; m_cr = 0; m_done = 0; m_valid = 1;
            return;
        end
        m_cr = 0;
        m_done = 0;
        if (!bus.BIT_TICK) return;
        nb = bus.T0 ? 0 : (m_bit + 1) % 29;
        case (m_st)
            M_HALT:   if (bus.GO) m_st = M_WAIT_N;
            M_WAIT_N: if (!bus.GO) m_st = M_HALT;
                      else if (bus.T0 && bus.N_MATCH) m_st = M_READ;
            M_READ:   if (bus.T0) begin
                          m_left = xfer_len(int'(bus.XFER_WORDS));
                          m_st = (bus.IMMEDIATE || bus.T_MATCH) ? M_XFER : M_WAIT_T;
                      end else begin
                          m_cr = (nb != 0);
                      end
            M_WAIT_T: if (bus.T0 && bus.T_MATCH) m_st = M_XFER;
            M_XFER:   if (bus.T0) begin
                          m_left--;
                          if (m_left == 0) begin
                              m_done = 1;
                              if (!bus.GO || bus.SINGLE_CMD) m_st = M_HALT;
                              else m_st = bus.N_MATCH ? M_READ : M_WAIT_N;
                          end
                      end
            default:  m_st = M_HALT;
        endcase
        m_bit = nb;
    endtask

    function automatic logic [11:0] model_vec();
        return {m_st == M_READ, m_st == M_XFER, m_st == M_WAIT_N, m_st == M_WAIT_T,
                m_st == M_HALT, m_cr, m_done, 5'(m_bit)};
    endfunction

    int rc_bits, tr_bits, wtr_bits, cr_cnt, done_cnt;

    task automatic clear_counts();
        rc_bits = 0; tr_bits = 0; wtr_bits = 0; cr_cnt = 0; done_cnt = 0;
    endtask

    task automatic step(input logic r, input logic b, input logic t);
        logic [11:0] dv;
        rst = r;
        bus.BIT_TICK = b;
        bus.T0 = t;
        if (b && !r) begin
            if (bus.RC === 1'b1)      rc_bits++;
            if (bus.TR === 1'b1)      tr_bits++;
            if (bus.WAIT_TR === 1'b1) wtr_bits++;
        end
        @(posedge CLOCK);
        model_step();
        #1;
        dv = {bus.RC, bus.TR, bus.WAIT_RC, bus.WAIT_TR, bus.HALTED, bus.CR, bus.CMD_DONE, bus.BIT_NUM};
        if (m_valid) chk("model", 32'(dv), 32'(model_vec()));
        if (bus.CR === 1'b1)       cr_cnt++;
        if (bus.CMD_DONE === 1'b1) done_cnt++;
    endtask

    task automatic tick(input logic t);
        step(1'b0, 1'b1, t);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic word(input logic nm, input logic tm, input int nticks);
        bus.N_MATCH = nm;
        bus.T_MATCH = tm;
        tick(1'b1);
        bus.N_MATCH = 1'b0;
        bus.T_MATCH = 1'b0;
        for (int i = 1; i < nticks; i++) tick(1'b0);
    endtask

    typedef struct {
        logic       rst, bt, t0, go, nm;
        logic [4:0] bitn;
        logic       halted, wrc, rc, cr;
    } vec_t;

    function automatic vec_t mk(input int r, b, t, g, n, bn, h, w, rc, cr);
        vec_t v;
        v.rst = (r != 0); v.bt = (b != 0); v.t0 = (t != 0); v.go = (g != 0); v.nm = (n != 0);
        v.bitn = 5'(bn); v.halted = (h != 0); v.wrc = (w != 0); v.rc = (rc != 0); v.cr = (cr != 0);
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        bus.BIT_TICK = 0; bus.T0 = 0; bus.N_MATCH = 0; bus.T_MATCH = 0;
        bus.IMMEDIATE = 0; bus.XFER_WORDS = '0; bus.GO = 1; bus.SINGLE_CMD = 0;
        rst = 1;
        clear_counts();

        //            rst bt t0 go nm  bit hlt wrc rc cr
        tbl[0]  = mk(1, 0, 0, 1, 0,  0, 1, 0, 0, 0);
        tbl[1]  = mk(1, 1, 0, 1, 0,  0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 1, 0,  0, 1, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 1, 0,  1, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 1, 1, 1,  1, 0, 1, 0, 0);
        tbl[5]  = mk(0, 1, 0, 1, 0,  2, 0, 1, 0, 0);
        tbl[6]  = mk(0, 1, 1, 1, 0,  0, 0, 1, 0, 0);
        tbl[7]  = mk(0, 1, 0, 1, 0,  1, 0, 1, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0,  1, 0, 1, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 0,  2, 1, 0, 0, 0);
        tbl[10] = mk(0, 0, 0, 1, 0,  2, 1, 0, 0, 0);
        tbl[11] = mk(0, 1, 0, 1, 0,  3, 0, 1, 0, 0);
        tbl[12] = mk(0, 1, 1, 1, 1,  0, 0, 0, 1, 0);
        tbl[13] = mk(0, 1, 0, 1, 0,  1, 0, 0, 1, 1);
        tbl[14] = mk(0, 0, 0, 1, 0,  1, 0, 0, 1, 0);
        tbl[15] = mk(0, 1, 1, 1, 0,  0, 0, 0, 0, 0);
        tbl[16] = mk(1, 0, 0, 1, 0,  0, 1, 0, 0, 0);

        for (int i = 0; i < 17; i++) begin
            bus.GO = tbl[i].go;
            bus.N_MATCH = tbl[i].nm;
            step(tbl[i].rst, tbl[i].bt, tbl[i].t0);
            chk($sformatf("vec%0d", i),
                32'({bus.BIT_NUM, bus.HALTED, bus.WAIT_RC, bus.RC, bus.CR}),
                32'({tbl[i].bitn, tbl[i].halted, tbl[i].wrc, tbl[i].rc, tbl[i].cr}));
        end
        bus.N_MATCH = 0;

        // Bit counter wrap 28 -> 0 without a word mark (held halted with GO low).
        bus.GO = 0;
        for (int i = 0; i < 28; i++) tick(1'b0);
        chk("bit_28", 32'(bus.BIT_NUM), 32'd28);
        tick(1'b0);
        chk("bit_wrap", 32'(bus.BIT_NUM), 32'd0);

        // Reset with GO held, then one immediate single-word command.
        bus.GO = 1;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("rst_halted", 32'(bus.HALTED), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        tick(1'b0);
        chk("rst_wait_rc", 32'(bus.WAIT_RC), 32'd1);
        bus.IMMEDIATE = 1; bus.XFER_WORDS = 7'd0; bus.SINGLE_CMD = 1;
        clear_counts();
        word(1'b0, 1'b0, 29);
        word(1'b0, 1'b0, 29);
        word(1'b1, 1'b0, 29);
        word(1'b0, 1'b0, 29);
        tick(1'b1);
        chk("imm_rc_bits", 32'(rc_bits), 32'd29);
        chk("imm_cr_cnt", 32'(cr_cnt), 32'd28);
        chk("imm_tr_bits", 32'(tr_bits), 32'd29);
        chk("imm_done", 32'(done_cnt), 32'd1);
        chk("imm_halted", 32'(bus.HALTED), 32'd1);

        // Deferred command, T match four words after the command word, 3-word transfer.
        bus.SINGLE_CMD = 0; bus.IMMEDIATE = 0; bus.XFER_WORDS = 7'd3;
        word(1'b0, 1'b0, 29);
        word(1'b1, 1'b0, 29);
        clear_counts();
        word(1'b0, 1'b0, 29);
        for (int i = 0; i < 3; i++) word(1'b0, 1'b0, 29);
        word(1'b0, 1'b1, 29);
        word(1'b0, 1'b0, 29);
        word(1'b0, 1'b0, 29);
        tick(1'b1);
        chk("def_wtr_bits", 32'(wtr_bits), 32'd116);
        chk("def_tr_bits", 32'(tr_bits), 32'd87);
        chk("def_done", 32'(done_cnt), 32'd1);
        chk("def_wait_rc", 32'(bus.WAIT_RC), 32'd1);

        // Full-line transfer with single-command halt.
        bus.SINGLE_CMD = 1; bus.IMMEDIATE = 1; bus.XFER_WORDS = 7'd107;
        word(1'b1, 1'b0, 29);
        clear_counts();
        for (int i = 0; i < 108; i++) word(1'b0, 1'b0, 29);
        tick(1'b1);
        chk("line_tr_bits", 32'(tr_bits), 32'd3132);
        chk("line_done", 32'(done_cnt), 32'd1);
        chk("line_halted", 32'(bus.HALTED), 32'd1);

        // Reset at bit 14 of the command word.
        bus.SINGLE_CMD = 0; bus.IMMEDIATE = 1; bus.XFER_WORDS = 7'd0;
        word(1'b0, 1'b0, 29);
        clear_counts();
        word(1'b1, 1'b0, 15);
        chk("abort_bit", 32'(bus.BIT_NUM), 32'd14);
        step(1'b1, 1'b0, 1'b0);
        chk("abort_halted", 32'(bus.HALTED), 32'd1);
        chk("abort_cr_low", 32'(bus.CR), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        word(1'b0, 1'b0, 29);
        word(1'b0, 1'b0, 29);
        chk("abort_cr_cnt", 32'(cr_cnt), 32'd14);
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // GO dropped mid-transfer: transfer still completes, then halt.
        bus.XFER_WORDS = 7'd2;
        word(1'b1, 1'b0, 29);
        clear_counts();
        word(1'b0, 1'b0, 29);
        word(1'b0, 1'b0, 10);
        bus.GO = 0;
        for (int i = 0; i < 19; i++) tick(1'b0);
        chk("godrop_in_xfer", 32'(bus.TR), 32'd1);
        tick(1'b1);
        chk("godrop_tr_bits", 32'(tr_bits), 32'd58);
        chk("godrop_done", 32'(done_cnt), 32'd1);
        chk("godrop_halted", 32'(bus.HALTED), 32'd1);

        // GO dropped while waiting for N: halt on the next bit tick only.
        bus.GO = 1;
        tick(1'b0);
        chk("waitn_entered", 32'(bus.WAIT_RC), 32'd1);
        bus.GO = 0;
        step(1'b0, 1'b0, 1'b0);
        chk("waitn_hold", 32'(bus.WAIT_RC), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        chk("waitn_halted", 32'(bus.HALTED), 32'd1);

        // Randomized traffic against the reference model.
        bus.GO = 1;
        for (int i = 0; i < 15000; i++) begin
            logic b, t, r;
            b = ($urandom_range(0, 2) == 0);
            t = 1'b0;
            if (b && m_bit == 28 && $urandom_range(0, 9) != 0) t = 1'b1;
            else if ($urandom_range(0, 39) == 0) t = 1'b1;
            r = ($urandom_range(0, 1999) == 0);
            if (bus.GO && $urandom_range(0, 399) == 0) bus.GO = 0;
            else if (!bus.GO && $urandom_range(0, 39) == 0) bus.GO = 1;
            if ($urandom_range(0, 299) == 0) bus.SINGLE_CMD = ~bus.SINGLE_CMD;
            bus.N_MATCH = ($urandom_range(0, 3) == 0);
            bus.T_MATCH = ($urandom_range(0, 3) == 0);
            bus.IMMEDIATE = 1'($urandom_range(0, 1));
            bus.XFER_WORDS = 7'($urandom_range(0, 5));
            step(r, b, t);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
